fsm_ctrl_responder: RTL and testbench
=====================================

// Module: fsm_ctrl_responder
// PURPOSE
//  Main control FSM for the FIFO datapath. Responds to init, threshold and
//  FIFO status stimulus; latches thresholds and reports link state.
//  Sits between the configuration source and the FIFO bank.
//  Drives the packed threshold bus and one-hot active/idle/error flags.
// PARAMETERS
//  NUM_FIFOS  5  number of monitored FIFOs (width of FIFO_error/FIFO_empty)
//  IDLE_HOLD  2  consecutive all-empty cycles needed to leave ACTIVE for IDLE (>=1)
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-high reset
//  init        in   1          request (re)configuration
//  umbral_MF   in   2          main-FIFO threshold
//  umbral_VC0  in   4          VC0 threshold
//  umbral_VC1  in   4          VC1 threshold
//  umbral_D0   in   2          D0 threshold
//  umbral_D1   in   2          D1 threshold
//  FIFO_error  in   NUM_FIFOS  per-FIFO error (overflow/underflow) flags
//  FIFO_empty  in   NUM_FIFOS  per-FIFO empty flags
//  umbrales_I  out  14         latched thresholds {MF,VC0,VC1,D0,D1} (MSB..LSB)
//  active_out  out  1          state==ACTIVE
//  idle_out    out  1          state==IDLE
//  error_out   out  1          state==ERROR
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-operation): state=RESET, umbrales_I=0,
//    active/idle/error=0, idle-hold counter=0.
//  - State register updates on posedge clk; flags decoded from state register
//    only (no input->output combinational path); flag latency 1 clk after event.
//  - States: RESET, INIT, IDLE, ACTIVE, ERROR (3-bit encoding).
//  - Priority in every non-RESET state: |FIFO_error > init > FIFO_empty.
//  - RESET -> INIT on first posedge after reset deasserts (unconditional).
//  - INIT: umbrales_I <= {umbral_MF,umbral_VC0,umbral_VC1,umbral_D0,umbral_D1}
//    on every clk in INIT; any FIFO_error -> ERROR; init=0 -> IDLE.
//  - IDLE: FIFO_error -> ERROR; init=1 -> INIT; FIFO_empty != all-ones -> ACTIVE.
//  - ACTIVE: FIFO_error -> ERROR; init=1 -> INIT; counter increments each clk
//    FIFO_empty==all-ones, clears otherwise; reaching IDLE_HOLD -> IDLE, clear.
//  - ERROR: sticky; only reset exits. init/FIFO_empty ignored.
//  - umbrales_I holds its value outside INIT; not cleared by ERROR.
//  - Counter saturates at IDLE_HOLD; cleared on any exit from ACTIVE.
//  - Inputs assumed synchronous to clk; no synchronizers inside.
// CONFIGURATION
//  ERR_SRC_CAPTURE_EN defined: extra port error_src out NUM_FIFOS; loaded with
//    FIFO_error on the clk entering ERROR, held while in ERROR, 0 on reset.
//  Not defined: port and capture register absent; all else identical.
// TESTING
//  1 reset=1 3 clk then 0 -> next clk INIT, umbrales_I=0, flags all 0.
//  2 INIT, MF=1,VC0=1,VC1=1,D0=1,D1=1, init=1 -> umbrales_I=14'b01_0001_0001_01_01.
//  3 init=0, FIFO_empty=5'b11111 -> IDLE, idle_out=1; FIFO_empty=5'b00000 ->
//    ACTIVE next clk; all-ones 2 clk -> idle_out=1 after 2nd clk (IDLE_HOLD=2).
//  4 ACTIVE, FIFO_error=5'b10100 with init=1 -> ERROR (error wins), error_out=1;
//    FIFO_error=0 and init toggles -> stays ERROR; error_src=5'b10100 if enabled.
//  5 reset pulse mid-ACTIVE (between edges) -> flags 0 immediately, umbrales_I=0,
//    RESET then INIT.
//  6 IDLE, init=1 with new thresholds MF=3,VC1=12,D1=3 -> INIT; umbrales_I
//    updates; other states after init=0 keep it.

Source files
------------

// File: rtl/fsm_ctrl_responder.sv
// Control FSM for the FIFO datapath: latches thresholds in INIT and reports the link state.
// Optional feature macro ERR_SRC_CAPTURE_EN adds the error_src capture port.
module fsm_ctrl_responder #(
   parameter int NUM_FIFOS = 5,
   parameter int IDLE_HOLD = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init,
   input  logic [1:0]           umbral_MF,
   input  logic [3:0]           umbral_VC0,
   input  logic [3:0]           umbral_VC1,
   input  logic [1:0]           umbral_D0,
   input  logic [1:0]           umbral_D1,
   input  logic [NUM_FIFOS-1:0] FIFO_error,
   input  logic [NUM_FIFOS-1:0] FIFO_empty,
   output logic [13:0]          umbrales_I,
   output logic                 active_out,
   output logic                 idle_out,
`ifdef ERR_SRC_CAPTURE_EN
   output logic [NUM_FIFOS-1:0] error_src,
`endif
   output logic                 error_out
);

   localparam int CW = $clog2(IDLE_HOLD + 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] HOLD_M1  = CW'(IDLE_HOLD - 1);

   localparam logic [2:0] ST_RESET  = 3'd0;
   localparam logic [2:0] ST_INIT   = 3'd1;
   localparam logic [2:0] ST_IDLE   = 3'd2;
   localparam logic [2:0] ST_ACTIVE = 3'd3;
   localparam logic [2:0] ST_ERROR  = 3'd4;

   logic [2:0]    r_state;
   logic [2:0]    w_next_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [13:0]   r_umb;
   logic [13:0]   w_umb_nxt;
   logic          r_active;
   logic          r_idle;
   logic          r_error;
   logic          w_active_nxt;
   logic          w_idle_nxt;
   logic          w_error_nxt;
   logic          w_any_err;
   logic          w_all_empty;

   assign w_any_err   = |FIFO_error;
   assign w_all_empty = &FIFO_empty;

   // State and idle-hold counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RESET;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic; priority is error > init > empty in every non-RESET state
   always_comb begin
      w_next_state = r_state;
      w_cnt_nxt    = CNT_ZERO;
      case (r_state)
         ST_RESET: begin
            w_next_state = ST_INIT;
         end
         ST_INIT: begin
            if (w_any_err) begin
               w_next_state = ST_ERROR;
            end else if (!init) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_INIT;
            end
         end
         ST_IDLE: begin
            if (w_any_err) begin
               w_next_state = ST_ERROR;
            end else if (init) begin
               w_next_state = ST_INIT;
            end else if (!w_all_empty) begin
               w_next_state = ST_ACTIVE;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (w_any_err) begin
               w_next_state = ST_ERROR;
            end else if (init) begin
               w_next_state = ST_INIT;
            end else if (w_all_empty) begin
               // The hold count includes the current all-empty cycle
               if (r_cnt >= HOLD_M1) begin
                  w_next_state = ST_IDLE;
               end else begin
                  w_next_state = ST_ACTIVE;
                  w_cnt_nxt    = r_cnt + CNT_ONE;
               end
            end else begin
               w_next_state = ST_ACTIVE;
            end
         end
         ST_ERROR: begin
            w_next_state = ST_ERROR;
         end
         default: begin
            w_next_state = ST_RESET;
         end
      endcase
   end

   // Output decode, computed from the next state so the registered flags track the state register
   always_comb begin
      w_active_nxt = (w_next_state == ST_ACTIVE);
      w_idle_nxt   = (w_next_state == ST_IDLE);
      w_error_nxt  = (w_next_state == ST_ERROR);
      if (r_state == ST_INIT) begin
         w_umb_nxt = {umbral_MF, umbral_VC0, umbral_VC1, umbral_D0, umbral_D1};
      end else begin
         w_umb_nxt = r_umb;
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_umb    <= 14'd0;
         r_active <= 1'b0;
         r_idle   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_umb    <= w_umb_nxt;
         r_active <= w_active_nxt;
         r_idle   <= w_idle_nxt;
         r_error  <= w_error_nxt;
      end
   end

`ifdef ERR_SRC_CAPTURE_EN
   logic [NUM_FIFOS-1:0] r_err_src;

   // Capture the error vector on the edge entering ERROR, then hold it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_src <= {NUM_FIFOS{1'b0}};
      end else if ((r_state != ST_ERROR) && (w_next_state == ST_ERROR)) begin
         r_err_src <= FIFO_error;
      end else begin
         r_err_src <= r_err_src;
      end
   end

   assign error_src = r_err_src;
`endif

   assign umbrales_I = r_umb;
   assign active_out = r_active;
   assign idle_out   = r_idle;
   assign error_out  = r_error;

endmodule

// File: tb/tb_fsm_ctrl_responder.sv
// Scoreboard bench for fsm_ctrl_responder; expected values are queued when stimulus is driven.
`timescale 1ns/1ps
module tb_fsm_ctrl_responder;

   typedef struct {
      string       tag;
      logic [2:0]  flags;
      logic [13:0] umb;
      logic [4:0]  esrc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [1:0] umbral_MF, umbral_D0, umbral_D1;
   logic [3:0] umbral_VC0, umbral_VC1;
   logic [4:0] FIFO_error, FIFO_empty;
   logic [13:0] umbrales_I;
   logic       active_out, idle_out, error_out;
   logic [4:0] error_src_obs;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb_q[$];

   localparam logic [13:0] UMB1 = 14'b01_0001_0001_01_01;
   localparam logic [13:0] UMB2 = {2'd3, 4'd1, 4'd12, 2'd1, 2'd3};

`ifdef ERR_SRC_CAPTURE_EN
   logic [4:0] error_src;
   assign error_src_obs = error_src;
`else
   assign error_src_obs = 5'd0;
`endif

   fsm_ctrl_responder #(.NUM_FIFOS(5), .IDLE_HOLD(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .init       (init),
      .umbral_MF  (umbral_MF),
      .umbral_VC0 (umbral_VC0),
      .umbral_VC1 (umbral_VC1),
      .umbral_D0  (umbral_D0),
      .umbral_D1  (umbral_D1),
      .FIFO_error (FIFO_error),
      .FIFO_empty (FIFO_empty),
      .umbrales_I (umbrales_I),
      .active_out (active_out),
      .idle_out   (idle_out),
`ifdef ERR_SRC_CAPTURE_EN
      .error_src  (error_src),
`endif
      .error_out  (error_out)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input exp_t e);
      check_val({e.tag, "_flags"}, {29'd0, active_out, idle_out, error_out}, {29'd0, e.flags});
      check_val({e.tag, "_umb"}, {18'd0, umbrales_I}, {18'd0, e.umb});
`ifdef ERR_SRC_CAPTURE_EN
      check_val({e.tag, "_esrc"}, {27'd0, error_src_obs}, {27'd0, e.esrc});
`endif
   endtask

   // Push the expectation for the current stimulus, advance one edge, pop and compare
   task automatic cycle(input string tag, input logic [2:0] flags, input logic [13:0] umb,
                        input logic [4:0] esrc);
      exp_t e;
      e.tag = tag; e.flags = flags; e.umb = umb; e.esrc = esrc;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         check_outputs(sb_q.pop_front());
      end
   endtask

   task automatic set_thr(input logic [1:0] mf, input logic [3:0] vc0, input logic [3:0] vc1,
                          input logic [1:0] d0, input logic [1:0] d1);
      umbral_MF = mf; umbral_VC0 = vc0; umbral_VC1 = vc1; umbral_D0 = d0; umbral_D1 = d1;
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic async_reset(input string tag);
      exp_t e;
      #2 reset = 1'b1;
      #1;
      e.tag = tag; e.flags = 3'b000; e.umb = 14'd0; e.esrc = 5'd0;
      check_outputs(e);
      #1 reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      reset = 1'b1; init = 1'b0;
      set_thr(2'd0, 4'd0, 4'd0, 2'd0, 2'd0);
      FIFO_error = 5'd0; FIFO_empty = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      e.tag = "reset"; e.flags = 3'b000; e.umb = 14'd0; e.esrc = 5'd0;
      check_outputs(e);
      reset = 1'b0;

      set_thr(2'd1, 4'd1, 4'd1, 2'd1, 2'd1); init = 1'b1;
      cycle("rst_to_init", 3'b000, 14'd0, 5'd0);
      cycle("init_load",   3'b000, UMB1,  5'd0);

      init = 1'b0; FIFO_empty = 5'b11111;
      cycle("to_idle",     3'b010, UMB1, 5'd0);
      FIFO_empty = 5'b00000;
      cycle("to_active",   3'b100, UMB1, 5'd0);
      FIFO_empty = 5'b11111;
      cycle("hold1",       3'b100, UMB1, 5'd0);
      cycle("hold2",       3'b010, UMB1, 5'd0);

      FIFO_empty = 5'b00000;
      cycle("reactive",    3'b100, UMB1, 5'd0);
      FIFO_empty = 5'b11111;
      cycle("cnt1",        3'b100, UMB1, 5'd0);
      FIFO_empty = 5'b01111;
      cycle("cnt_clr",     3'b100, UMB1, 5'd0);
      FIFO_empty = 5'b11111;
      cycle("cnt_a",       3'b100, UMB1, 5'd0);
      cycle("cnt_b",       3'b010, UMB1, 5'd0);
      FIFO_empty = 5'b00000;
      cycle("active_again",3'b100, UMB1, 5'd0);

      FIFO_error = 5'b10100; init = 1'b1;
      cycle("err_wins",    3'b001, UMB1, 5'b10100);
      FIFO_error = 5'd0; init = 1'b0;
      cycle("err_sticky0", 3'b001, UMB1, 5'b10100);
      init = 1'b1; FIFO_empty = 5'b11111;
      cycle("err_sticky1", 3'b001, UMB1, 5'b10100);
      FIFO_error = 5'b00011;
      cycle("err_hold_src",3'b001, UMB1, 5'b10100);

      FIFO_error = 5'd0; init = 1'b0; FIFO_empty = 5'b11111;
      async_reset("rst_in_error");
      cycle("rst_init",    3'b000, 14'd0, 5'd0);
      cycle("rst_idle",    3'b010, UMB1,  5'd0);
      FIFO_empty = 5'b00000;
      cycle("rst_active",  3'b100, UMB1,  5'd0);

      async_reset("rst_mid_active");
      cycle("rst2_init",   3'b000, 14'd0, 5'd0);
      cycle("rst2_idle",   3'b010, UMB1,  5'd0);

      FIFO_empty = 5'b11111;
      set_thr(2'd3, 4'd1, 4'd12, 2'd1, 2'd3); init = 1'b1;
      cycle("idle_init",   3'b000, UMB1, 5'd0);
      init = 1'b0;
      cycle("init_new",    3'b010, UMB2, 5'd0);
      set_thr(2'd0, 4'd0, 4'd0, 2'd0, 2'd0); FIFO_empty = 5'b00000;
      cycle("thr_hold_act",3'b100, UMB2, 5'd0);
      FIFO_empty = 5'b11111;
      cycle("thr_hold_a",  3'b100, UMB2, 5'd0);
      cycle("thr_hold_b",  3'b010, UMB2, 5'd0);

      init = 1'b1; FIFO_empty = 5'b00000;
      cycle("init_over_empty", 3'b000, UMB2, 5'd0);
      FIFO_error = 5'b00001;
      cycle("init_err",    3'b001, 14'd0, 5'b00001);

      if (sb_q.size() != 0) begin
         check_val("sb_leftover", sb_q.size(), 32'd0);
      end else begin
         check_val("sb_drained", sb_q.size(), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
